// File: rtl/serial_add_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : serial_add_pkg                                                    |
// | Brief  : Shared state encodings and default width for the serial adder.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : serial_add_ctrl_if                                                |
// | Brief  : Request/result bundle between harness and serial adder; ovf wire  |
// |          exists only when SERIAL_ADD_OVF_EN is defined.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : full_adder                                                        |
// | Brief  : One-bit full adder cell shared by the serial datapath.            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module full_adder (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_cin,
  output logic      o_sum,
  output logic      o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : serial_add_ctrl                                                   |
// | Brief  : Bit-serial adder controller, LSB first, one full_adder instance.  |
// |          Optional signed-overflow flag via SERIAL_ADD_OVF_EN.              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic        clk,
  input  wire logic        reset,
  serial_add_ctrl_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ss;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_ss_nxt;

  full_adder u_full_adder (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // New sum bit enters at the MSB so after WIDTH steps the LSB lands in bit 0.
  assign w_ss_nxt = {w_fa_sum, r_ss[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_ss    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_sa    <= bus.a;
      r_sb    <= bus.b;
      r_ss    <= '0;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_ss    <= w_ss_nxt;
      r_carry <= w_fa_cout;
      if (w_last) begin
        r_sum  <= w_ss_nxt;
        r_cout <= w_fa_cout;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // r_carry still holds the carry into the MSB during the final step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_ovf <= 1'b0;
    else if (r_state == S_RUN && w_last)  r_ovf <= r_carry ^ w_fa_cout;
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_serial_add_ctrl                                                |
// | Brief  : Self-checking bench for serial_add_ctrl against an arithmetic     |
// |          reference model; ovf checked when SERIAL_ADD_OVF_EN is defined.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_serial_add_ctrl;
  localparam int W      = 8;
  localparam int PERIOD = 10;

  logic clk;
  logic reset;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  time          t_prev = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_sum"}, 64'(bus.sum), 64'(m_sum));
    chk({tag, "_cout"}, 64'(bus.cout), 64'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'(m_ovf));
`endif
  endtask

  // One operation; the call starts at the first negedge so consecutive calls
  // present start at the earliest legal edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                        input bit noise, input bit b2b);
    logic [W:0] r;
    int         n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tbv;
    bus.cin   = tc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.done && n <= W + 4) begin
      chk("sum_hold", 64'(bus.sum), 64'(m_sum));
      chk("cout_hold", 64'(bus.cout), 64'(m_cout));
      if (noise) begin
        bus.start = 1'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    r      = (W+1)'(ta) + (W+1)'(tbv) + (W+1)'(tc);
    m_sum  = r[W-1:0];
    m_cout = r[W];
    m_ovf  = (ta[W-1] == tbv[W-1]) && (r[W-1] != ta[W-1]);
    chk("latency_edges", 64'(n), 64'(W));
    chk("done_high", 64'(bus.done), 64'd1);
    chk_result("result");
    if (b2b) chk("b2b_spacing", 64'($time - t_prev), 64'((W + 2) * PERIOD));
    t_prev = $time;
    @(posedge clk);
    #1;
    chk("done_single", 64'(bus.done), 64'd0);
    chk("busy_fall", 64'(bus.busy), 64'd0);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      chk("idle_done", 64'(bus.done), 64'd0);
      chk("idle_busy", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk_result("rst");
    reset = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    idle_cycles(2);
    run_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a RUN, away from any clock edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h66;
    bus.cin   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    m_sum  = '0;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk_result("midrst");
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(W + 3);
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);

    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle_cycles(gap);
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), gap == 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
